// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, the reservation source,
// and the register-file write port / busy scoreboard.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;

    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]  wdata;
    logic [REG_NUM-1:0] busy;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output rsv_valid, rsv_addr,
        input  a_ready, b_ready,
        input  we, waddr, wdata, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  rsv_valid, rsv_addr,
        output a_ready, b_ready,
        output we, waddr, wdata, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline commit (A)
// and the long-latency unit (B), and tracks registers reserved by B operations.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int REG_NUM      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic               grant_a;
    logic               grant_b;
    logic               promote_b;
    logic [3:0]         starve_cnt;
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_nxt;
    logic               we_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;

    assign promote_b = (starve_cnt == LIMIT);

    // A wins by default; B takes the port when A is idle or B has been starved long enough.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (bus.b_valid && (promote_b || !bus.a_valid)) begin
                grant_b = 1'b1;
            end else if (bus.a_valid) begin
                grant_a = 1'b1;
            end
        end
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    // Set takes priority over clear so a re-reservation in the retiring cycle survives.
    always_comb begin
        busy_nxt = busy_q;
        for (int r = 1; r < REG_NUM; r++) begin
            if (grant_b && bus.b_addr == ADDR_W'(r)) begin
                busy_nxt[r] = 1'b0;
            end
            if (bus.rsv_valid && bus.rsv_addr == ADDR_W'(r)) begin
                busy_nxt[r] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            starve_cnt <= '0;
        end else begin
            we_q <= 1'b0;
            // Writes to register 0 complete the handshake but never reach the regfile.
            if (grant_a && bus.a_addr != '0) begin
                we_q    <= 1'b1;
                waddr_q <= bus.a_addr;
                wdata_q <= bus.a_data;
            end else if (grant_b && bus.b_addr != '0) begin
                we_q    <= 1'b1;
                waddr_q <= bus.b_addr;
                wdata_q <= bus.b_data;
            end

            if (!bus.b_valid || grant_b) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            busy_q <= busy_nxt;
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.busy  = busy_q;

endmodule
